// File: rtl/ysyx_22040750_mul_ctrl.sv
// Execute-stage front end for the serial radix-4 Booth multiplier: accepts RV64M multiply ops,
// issues them to the multiplier, formats the 128-bit product and holds it for writeback.
module ysyx_22040750_mul_ctrl #(
  parameter bit ZERO_BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [63:0]   src1,
  input  logic [63:0]   src2,
  output logic          mul_valid,
  output logic [63:0]   mul1,
  output logic [63:0]   mul2,
  output logic [1:0]    sext_flag,
  input  logic          P_valid,
  input  logic [127:0]  P,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] mul1_q, mul1_d;
  logic [63:0] mul2_q, mul2_d;
  logic [1:0]  sext_q, sext_d;
  logic [63:0] result_q, result_d;

  logic [2:0]  op_norm;
  logic        zero_op;
  logic [63:0] p_fmt;

  // Reserved encodings collapse to MUL at accept, so op_q only ever holds the five real ops.
  assign op_norm = (op > OP_MULW) ? OP_MUL : op;
  assign zero_op = ZERO_BYPASS && ((src1 == 64'd0) || (src2 == 64'd0));

  always_comb begin
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: p_fmt = P[127:64];
      OP_MULW:                      p_fmt = {{32{P[31]}}, P[31:0]};
      default:                      p_fmt = P[63:0];
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d  = state_q;
    op_d     = op_q;
    mul1_d   = mul1_q;
    mul2_d   = mul2_q;
    sext_d   = sext_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (!flush && in_valid) begin
          op_d   = op_norm;
          mul1_d = src1;
          mul2_d = src2;
          case (op_norm)
            OP_MULH:   sext_d = 2'b11;
            OP_MULHSU: sext_d = 2'b10;
            OP_MULW: begin
              // Zeroed upper halves let the multiplier terminate early on word ops.
              mul1_d = {32'd0, src1[31:0]};
              mul2_d = {32'd0, src2[31:0]};
              sext_d = 2'b00;
            end
            default:   sext_d = 2'b00;
          endcase
          if (zero_op) begin
            result_d = 64'd0;
            state_d  = S_DONE;
          end else begin
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = flush ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (P_valid) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            result_d = p_fmt;
            state_d  = S_DONE;
          end
        end else if (flush) begin
          // The multiplier cannot be aborted, so its stale product must be drained first.
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (P_valid) state_d = S_IDLE;
      S_DONE:  if (flush || out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      mul1_q   <= 64'd0;
      mul2_q   <= 64'd0;
      sext_q   <= 2'b00;
      result_q <= 64'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q  <= state_d;
      op_q     <= op_d;
      mul1_q   <= mul1_d;
      mul2_q   <= mul2_d;
      sext_q   <= sext_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign mul_valid = (state_q == S_ISSUE) && !flush;
  assign out_valid = (state_q == S_DONE);
  assign mul1      = mul1_q;
  assign mul2      = mul2_q;
  assign sext_flag = sext_q;
  assign result    = result_q;

endmodule

// File: tb/tb_ysyx_22040750_mul_ctrl.sv
// Directed bench for ysyx_22040750_mul_ctrl with a behavioural multiplier of programmable latency.
module tb_ysyx_22040750_mul_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [63:0]  src1 = 64'd0;
  logic [63:0]  src2 = 64'd0;
  logic         mul_valid;
  logic [63:0]  mul1;
  logic [63:0]  mul2;
  logic [1:0]   sext_flag;
  logic         P_valid = 1'b0;
  logic [127:0] P = 128'd0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  result;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int mul_lat  = 3;
  int pulses   = 0;

  logic         busy = 1'b0;
  int           cnt = 0;
  logic [127:0] prod = 128'd0;
  logic [127:0] ea, eb;

  ysyx_22040750_mul_ctrl #(.ZERO_BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .src1(src1), .src2(src2),
    .mul_valid(mul_valid), .mul1(mul1), .mul2(mul2), .sext_flag(sext_flag),
    .P_valid(P_valid), .P(P),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  always #5 clk = ~clk;

  // Multiplier model: samples mid-cycle, returns the product mul_lat cycles after the load pulse.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    = 1'b0;
      cnt     = 0;
      P_valid = 1'b0;
      P       = 128'd0;
    end else begin
      P_valid = 1'b0;
      P       = {$urandom, $urandom, $urandom, $urandom};
      if (busy) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          P_valid = 1'b1;
          P       = prod;
          busy    = 1'b0;
        end
      end
      if (mul_valid) begin
        ea     = sext_flag[1] ? {{64{mul1[63]}}, mul1} : {64'd0, mul1};
        eb     = sext_flag[0] ? {{64{mul2[63]}}, mul2} : {64'd0, mul2};
        prod   = ea * eb;
        cnt    = mul_lat;
        busy   = 1'b1;
        pulses = pulses + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one op, checks the issued operands, latency and result, then holds in DONE for 'hold' cycles.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp1, input logic [63:0] exp2, input logic [1:0] exps,
                       input logic [63:0] expr, input int hold);
    int p0;
    int n;
    p0 = pulses;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; op = o; src1 = a; src2 = b;
    tick();
    in_valid = 1'b0;
    #1;
    check({tag, "_mul_valid"}, mul_valid, 1'b1);
    check({tag, "_mul1"}, mul1, exp1);
    check({tag, "_mul2"}, mul2, exp2);
    check({tag, "_sext"}, sext_flag, exps);
    n = 0;
    while (!out_valid && n < 60) begin
      tick();
      #1;
      n++;
    end
    check({tag, "_latency"}, n, mul_lat + 1);
    check({tag, "_result"}, result, expr);
    for (int i = 0; i < hold; i++) begin
      tick();
      #1;
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_result"}, result, expr);
    end
    check({tag, "_pulses"}, pulses - p0, 1);
  endtask

  task automatic accept_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check({tag, "_out_dropped"}, out_valid, 1'b0);
    check({tag, "_back_idle"}, in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mul_valid", mul_valid, 1'b0);
    check("rst_result", result, 64'd0);
    check("rst_mul1", mul1, 64'd0);
    check("rst_sext", sext_flag, 2'b00);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    // MUL 3 * -5 with result held for three cycles
    mul_lat = 3;
    do_op("mul", 3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 2'b00,
          64'hFFFF_FFFF_FFFF_FFF1, 3);
    accept_out("mul");

    mul_lat = 5;
    do_op("mulhu", 3'd3, '1, '1, '1, '1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    accept_out("mulhu");

    // Shortest multiplier latency: done strobe in the first WAIT cycle
    mul_lat = 1;
    do_op("mulh", 3'd1, '1, '1, '1, '1, 2'b11, 64'd0, 0);
    accept_out("mulh");

    // Longest multiplier latency
    mul_lat = 33;
    do_op("mulhsu", 3'd2, '1, '1, '1, '1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    accept_out("mulhsu");

    mul_lat = 4;
    do_op("mulw", 3'd4, 64'h0000_0000_7FFF_FFFF, 64'hCAFE_0000_0000_0002, 64'h0000_0000_7FFF_FFFF,
          64'd2, 2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 0);

    // No accept in the writeback handshake cycle
    in_valid = 1'b1; op = 3'd7; src1 = 64'd5; src2 = 64'd9;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("b2b_out_dropped", out_valid, 1'b0);
    check("b2b_idle", in_ready, 1'b1);
    check("b2b_no_issue", mul_valid, 1'b0);
    // Reserved op 7 behaves as MUL
    do_op("rsvd", 3'd7, 64'd5, 64'd9, 64'd5, 64'd9, 2'b00, 64'd45, 0);
    accept_out("rsvd");

    // Zero-operand bypass
    p0 = pulses;
    in_valid = 1'b1; op = 3'd0; src1 = 64'd0; src2 = 64'h1234;
    tick();
    in_valid = 1'b0;
    #1;
    check("byp_out_valid", out_valid, 1'b1);
    check("byp_result", result, 64'd0);
    check("byp_mul_valid", mul_valid, 1'b0);
    tick();
    #1;
    check("byp_hold_valid", out_valid, 1'b1);
    check("byp_pulses", pulses - p0, 0);
    accept_out("byp");

    // flush beats in_valid in IDLE
    p0 = pulses;
    in_valid = 1'b1; flush = 1'b1; op = 3'd0; src1 = 64'd6; src2 = 64'd7;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    #1;
    check("fl_idle_ready", in_ready, 1'b1);
    check("fl_idle_mul_valid", mul_valid, 1'b0);
    check("fl_idle_out_valid", out_valid, 1'b0);

    // flush in ISSUE suppresses the load pulse
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("fl_issue_mul_valid", mul_valid, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_issue_idle", in_ready, 1'b1);
    check("fl_issue_pulses", pulses - p0, 0);

    // flush together with the done strobe discards the product
    mul_lat = 2;
    p0 = pulses;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("fl_pv_idle", in_ready, 1'b1);
    check("fl_pv_out_valid", out_valid, 1'b0);
    tick();
    #1;
    check("fl_pv_no_late", out_valid, 1'b0);
    check("fl_pv_pulses", pulses - p0, 1);

    // flush 5 cycles after mul_valid: drain, next op waits for the stale product
    mul_lat = 12;
    p0 = pulses;
    in_valid = 1'b1; op = 3'd0; src1 = 64'h11; src2 = 64'h22;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b1; op = 3'd0; src1 = 64'd6; src2 = 64'd7;
    #1;
    n = 0;
    while (!in_ready && n < 60) begin
      check("drain_out_valid", out_valid, 1'b0);
      tick();
      #1;
      n++;
    end
    check("drain_cycles", n, 7);
    check("drain_pulses", pulses - p0, 1);
    mul_lat = 3;
    do_op("drain_next", 3'd0, 64'd6, 64'd7, 64'd6, 64'd7, 2'b00, 64'd42, 0);
    accept_out("drain_next");

    // flush while holding a result in DONE
    do_op("done_fl", 3'd3, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1_0000_0000, 2'b00,
          64'd1, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("done_fl_out_valid", out_valid, 1'b0);
    check("done_fl_idle", in_ready, 1'b1);

    // Asynchronous reset while waiting on the multiplier
    mul_lat = 10;
    in_valid = 1'b1; op = 3'd0; src1 = 64'd6; src2 = 64'd7;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_mul_valid", mul_valid, 1'b0);
    check("arst_result", result, 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1'b1);
    mul_lat = 6;
    do_op("post_rst", 3'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 2'b10,
          64'hFFFF_FFFF_FFFF_FFFF, 10);
    accept_out("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
